// File: rtl/ym3438_op_reg_file.sv
// Per-operator register file: host address/data decode, pending write,
// slot-synchronous commit with write-through, and slot-ordered readout.
module ym3438_op_reg_file #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          BANKS       = 2,
  parameter int          CH_PER_BANK = 3,
  parameter int          OPS         = 4,
  parameter logic [3:0]  REG_BASE    = 4'h3,
  parameter int          SLOTS       = BANKS * CH_PER_BANK * OPS,
  parameter int          SW          = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                  MCLK,
  input  logic                  nIC,
  input  logic                  clk_en,
  input  logic                  sync_in,
  input  logic [7:0]            data,
  input  logic                  bank_sel,
  input  logic                  write_addr_en,
  input  logic                  write_data_en,
  output logic                  busy,
  output logic                  write_done,
  output logic [SW-1:0]         slot_idx,
  output logic [DATA_WIDTH-1:0] slot_data,
  output logic                  frame_start
);

  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  logic [DATA_WIDTH-1:0] r_mem [SLOTS];
  logic [SW-1:0]         r_slot;
  logic [DATA_WIDTH-1:0] r_slot_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_valid;
  logic [8:0]            r_addr;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic [SW-1:0]         r_pend_slot;

  logic                  w_legal;
  logic [SW-1:0]         w_tgt;
  logic [SW-1:0]         w_next;
  logic                  w_commit;

  // Latched address fields: [1:0]=channel, [3:2]=operator, [8]=bank
  always_comb begin
    w_legal = r_valid
           && (r_addr[7:4] == REG_BASE)
           && (int'(r_addr[1:0]) < CH_PER_BANK)
           && (int'(r_addr[3:2]) < OPS)
           && (int'(r_addr[8]) < BANKS);
    w_tgt = SW'(int'(r_addr[3:2]) * CH_PER_BANK * BANKS
              + int'(r_addr[8]) * CH_PER_BANK
              + int'(r_addr[1:0]));
  end

  always_comb begin
    w_next = (sync_in || (r_slot == LAST)) ? '0 : r_slot + 1'b1;
    w_commit = clk_en && r_busy && (w_next == r_pend_slot);
  end

  always_ff @(posedge MCLK) begin
    if (nIC) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
      r_slot      <= '0;
      r_slot_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_pend_data <= '0;
      r_pend_slot <= '0;
    end else begin
      if (clk_en) begin
        r_slot      <= w_next;
        r_slot_data <= w_commit ? r_pend_data : r_mem[w_next];
        if (w_commit) r_mem[w_next] <= r_pend_data;
      end
      r_done <= w_commit;
      // Address write cancels any pending write; a new data write re-arms
      if (write_addr_en) begin
        r_valid <= |data[7:4];
        r_addr  <= {bank_sel, data};
        r_busy  <= 1'b0;
      end else if (write_data_en && w_legal) begin
        r_pend_data <= data[DATA_WIDTH-1:0];
        r_pend_slot <= w_tgt;
        r_busy      <= 1'b1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign write_done  = r_done;
  assign slot_idx    = r_slot;
  assign slot_data   = r_slot_data;
  assign frame_start = (r_slot == '0);

endmodule

// File: tb/tb_ym3438_op_reg_file.sv
// Bench for ym3438_op_reg_file: directed steps plus random traffic,
// every cycle compared against a slot-level behavioural model.
module tb_ym3438_op_reg_file;

  localparam int SLOTS = 24;
  localparam int SW    = 5;

  logic          MCLK = 1'b0;
  logic          nIC = 1'b1;
  logic          clk_en = 1'b0;
  logic          sync_in = 1'b0;
  logic [7:0]    data = '0;
  logic          bank_sel = 1'b0;
  logic          write_addr_en = 1'b0;
  logic          write_data_en = 1'b0;
  logic          busy;
  logic          write_done;
  logic [SW-1:0] slot_idx;
  logic [7:0]    slot_data;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  ym3438_op_reg_file dut (
    .MCLK(MCLK), .nIC(nIC), .clk_en(clk_en), .sync_in(sync_in),
    .data(data), .bank_sel(bank_sel),
    .write_addr_en(write_addr_en), .write_data_en(write_data_en),
    .busy(busy), .write_done(write_done), .slot_idx(slot_idx),
    .slot_data(slot_data), .frame_start(frame_start)
  );

  always #5 MCLK = ~MCLK;

  // Reference model state
  logic [7:0] m_mem [SLOTS];
  int         m_s;
  logic [7:0] m_sd;
  bit         m_busy, m_done, m_valid;
  logic [8:0] m_addr;
  logic [7:0] m_pd;
  int         m_ps;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(int ch, int bk, int op);
    return op * 6 + bk * 3 + ch;
  endfunction

  task automatic model_edge();
    int  ch, bk, op, nxt;
    bit  commit;
    if (nIC) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_s = 0; m_sd = 0; m_busy = 0; m_done = 0;
      m_valid = 0; m_addr = 0; m_pd = 0; m_ps = 0;
      return;
    end
    commit = 0;
    if (clk_en) begin
      nxt = (sync_in || m_s == SLOTS - 1) ? 0 : m_s + 1;
      commit = m_busy && (nxt == m_ps);
      if (commit) m_mem[nxt] = m_pd;
      m_s  = nxt;
      m_sd = m_mem[nxt];
    end
    m_done = commit;
    if (commit) m_busy = 0;
    if (write_addr_en) begin
      m_valid = (data[7:4] != 0);
      m_addr  = {bank_sel, data};
      m_busy  = 0;
    end else if (write_data_en && m_valid) begin
      ch = int'(m_addr[1:0]);
      op = int'(m_addr[3:2]);
      bk = int'(m_addr[8]);
      if (m_addr[7:4] == 4'h3 && ch < 3 && op < 4 && bk < 2) begin
        m_pd   = data;
        m_ps   = slot_of(ch, bk, op);
        m_busy = 1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ce, input bit sy,
                      input bit ae, input bit de,
                      input logic [7:0] d, input bit bk);
    nIC = rst; clk_en = ce; sync_in = sy;
    write_addr_en = ae; write_data_en = de;
    data = d; bank_sel = bk;
    @(posedge MCLK);
    model_edge();
    #1;
    chk("slot_idx", 32'(slot_idx), 32'(m_s));
    chk("slot_data", 32'(slot_data), 32'(m_sd));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("write_done", 32'(write_done), 32'(m_done));
    chk("frame_start", 32'(frame_start), 32'(m_s == 0));
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic wr(input logic [7:0] a, input bit bk, input logic [7:0] d);
    step(0, 0, 0, 1, 0, a, bk);
    step(0, 0, 0, 0, 1, d, bk);
  endtask

  initial begin
    int dones;
    logic [7:0] a;
    step(1, 0, 0, 0, 0, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h00, 0);
    tick(25);

    wr(8'h31, 0, 8'h0A);
    chk("busy_after_wr", 32'(busy), 32'd1);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (write_done) break;
    end
    chk("commit_seen", 32'(write_done), 32'd1);
    chk("commit_slot", 32'(slot_idx), 32'd1);
    chk("commit_data", 32'(slot_data), 32'h0A);
    tick(24);
    chk("reread_slot1", 32'(slot_data), 32'h0A);

    wr(8'h3E, 1, 8'h05);
    tick(24);

    wr(8'h33, 0, 8'h11);
    chk("ill_ch", 32'(busy), 32'd0);
    wr(8'h41, 0, 8'h12);
    chk("ill_base", 32'(busy), 32'd0);
    wr(8'h01, 0, 8'h13);
    chk("ill_valid", 32'(busy), 32'd0);
    tick(24);

    wr(8'h35, 0, 8'h07);
    step(0, 1, 0, 0, 1, 8'h09, 0);
    for (int i = 0; i < 26; i++) begin
      tick(1);
      dones += int'(write_done);
    end
    chk("single_done", 32'(dones), 32'd1);

    wr(8'h32, 1, 8'h44);
    step(0, 0, 0, 1, 0, 8'h32, 1);
    chk("addr_cancel", 32'(busy), 32'd0);
    tick(25);

    while (m_s != 10) tick(1);
    step(0, 1, 1, 0, 0, 8'h00, 0);
    chk("sync_to_0", 32'(slot_idx), 32'd0);

    wr(8'h30, 0, 8'h5A);
    step(1, 1, 0, 0, 0, 8'h00, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(25);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: a = {4'h3, 4'($urandom)};
        1: a = {4'($urandom_range(1, 15)), 4'($urandom)};
        2: a = {4'h0, 4'($urandom)};
        default: a = 8'($urandom);
      endcase
      step($urandom_range(399) == 0,
           $urandom_range(3) != 0,
           $urandom_range(49) == 0,
           $urandom_range(19) == 0,
           $urandom_range(7) == 0,
           $urandom_range(1) == 0 ? a : 8'($urandom),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
